// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        HOLD = 3'd3,
        DROP = 3'd4
    } fetch_state_t;

    localparam logic [1:0] CAUSE_NONE     = 2'd0;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'd1;
    localparam logic [1:0] CAUSE_MISALIGN = 2'd2;

    // addi x0,x0,0
    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Saturating cycle counter for fetch response timeouts; flags when the limit is reached.
module fetch_timeout_ctr #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en && (cnt_q != LIMIT)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expired = (cnt_q == LIMIT);

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: one outstanding imem request, valid/ready to decode, redirect flush and timeout.
// Optional misaligned-PC fault when FETCH_ALIGN_CHECK_EN is defined.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int                XLEN           = 32,
    parameter int                TIMEOUT_CYCLES = 255,
    parameter logic [XLEN-1:0]   NOP_INSTR      = XLEN'(NOP_WORD)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_i,
    input  logic            redirect_i,
    output logic            pc_en_o,
    output logic            imem_req_valid_o,
    input  logic            imem_req_ready_i,
    output logic [XLEN-1:0] imem_req_addr_o,
    input  logic            imem_rsp_valid_i,
    input  logic [XLEN-1:0] imem_rsp_data_i,
    output logic            instr_valid_o,
    input  logic            instr_ready_i,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] instr_pc_o,
    output logic            instr_fault_o,
    output logic [1:0]      instr_fault_cause_o
);

    fetch_state_t    state_q;
    logic [XLEN-1:0] instr_q;
    logic [XLEN-1:0] instr_pc_q;
    logic            fault_q;
    logic [1:0]      cause_q;

    logic misalign;
    logic req_accept;
    logic ctr_en;
    logic ctr_expired;

`ifdef FETCH_ALIGN_CHECK_EN
    assign misalign = (pc_i[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    assign imem_req_valid_o = (state_q == REQ) && !misalign;
    assign imem_req_addr_o  = (state_q == REQ) ? {pc_i[XLEN-1:2], 2'b00} : '0;
    assign req_accept       = imem_req_valid_o && imem_req_ready_i;

    // Counter runs from acceptance until the response (or its stale copy) is retired.
    assign ctr_en = (state_q == WAIT) || (state_q == DROP);

    fetch_timeout_ctr #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout_ctr (
        .clk    (clk),
        .rst    (rst),
        .clr    (req_accept),
        .en     (ctr_en),
        .expired(ctr_expired)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            instr_q    <= '0;
            instr_pc_q <= '0;
            fault_q    <= 1'b0;
            cause_q    <= CAUSE_NONE;
        end else begin
            case (state_q)
                IDLE: state_q <= REQ;

                REQ: begin
                    if (misalign && !redirect_i) begin
                        state_q    <= HOLD;
                        instr_q    <= NOP_INSTR;
                        instr_pc_q <= pc_i;
                        fault_q    <= 1'b1;
                        cause_q    <= CAUSE_MISALIGN;
                    end else if (req_accept) begin
                        instr_pc_q <= pc_i;
                        state_q    <= redirect_i ? DROP : WAIT;
                    end
                end

                WAIT: begin
                    if (imem_rsp_valid_i) begin
                        if (redirect_i) begin
                            state_q <= REQ;
                        end else begin
                            state_q <= HOLD;
                            instr_q <= imem_rsp_data_i;
                            fault_q <= 1'b0;
                            cause_q <= CAUSE_NONE;
                        end
                    end else if (redirect_i) begin
                        state_q <= DROP;
                    end else if (ctr_expired) begin
                        state_q <= HOLD;
                        instr_q <= NOP_INSTR;
                        fault_q <= 1'b1;
                        cause_q <= CAUSE_TIMEOUT;
                    end
                end

                // A redirect is already pending here, so only the stale response matters.
                DROP: begin
                    if (imem_rsp_valid_i || ctr_expired) begin
                        state_q <= REQ;
                    end
                end

                HOLD: begin
                    if (redirect_i || instr_ready_i) begin
                        state_q <= REQ;
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign instr_valid_o       = (state_q == HOLD);
    assign instr_o             = instr_q;
    assign instr_pc_o          = instr_pc_q;
    assign instr_fault_o       = fault_q;
    assign instr_fault_cause_o = cause_q;
    assign pc_en_o             = instr_valid_o && instr_ready_i && !redirect_i;

endmodule
